// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset sequencer: state encoding, widths, output decode.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pll_seq_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;
  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

  typedef enum logic [STATE_W-1:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } state_t;

  typedef struct packed {
    logic pll_resetb;
    logic sys_reset_n;
    logic ready;
    logic fail;
  } outs_t;

  // Largest of three cycle counts; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Output levels that belong to each state; registered by the sequencer.
  function automatic outs_t state_outputs(input state_t s);
    outs_t o;
    o.pll_resetb  = (s == WAIT_LOCK) || (s == STABLE) || (s == RUN);
    o.sys_reset_n = (s == RUN);
    o.ready       = (s == RUN);
    o.fail        = (s == FAILED);
    return o;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its surroundings.
// Latency: wires only.
// Backpressure: none; level and pulse signals.
interface pll_reset_sequencer_if;
  import pll_seq_pkg::*;

  logic               pll_locked;
  logic               restart;
  logic               pll_resetb;
  logic               sys_reset_n;
  logic               ready;
  logic               fail;
  logic [RETRY_W-1:0] retry_count;

  modport master (
    input  pll_locked, restart,
    output pll_resetb, sys_reset_n, ready, fail, retry_count
  );

  modport slave (
    output pll_locked, restart,
    input  pll_resetb, sys_reset_n, ready, fail, retry_count
  );

endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchroniser with async active-low clear; also usable for reset resync.
// Latency: STAGES clock cycles from d to q.
// Backpressure: none.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain; clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL RESETB, waits for a stable lock, then releases system reset; retries on timeout.
// Latency: outputs registered, 1 cycle after each state decision; lock seen SYNC_STAGES cycles late.
// Backpressure: none; restart is a one-cycle pulse accepted in any state.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 100000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 7,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  clock_in,
  input  logic                  resetb,
  pll_reset_sequencer_if.master seq
);

  localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  state_t             state_q;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [RETRY_W-1:0] retry_q;
  logic [RETRY_W-1:0] retry_nxt;
  logic [RETRY_W-1:0] retry_inc;
  outs_t              outs_q;
  logic               lock_s;

  // PLL LOCK comes from another clock domain; only the synchronised copy is trusted.
  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clock_in),
    .rst_n (resetb),
    .d     (seq.pll_locked),
    .q     (lock_s)
  );

  // Next-state, retry bookkeeping and phase counter; restart overrides everything.
  always_comb begin
    state_nxt = state_q;
    retry_nxt = retry_q;
    retry_inc = (retry_q == RETRY_SAT) ? retry_q : retry_q + 1'b1;
    cnt_nxt   = cnt_q + 1'b1;

    unique case (state_q)
      PLL_RESET: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_nxt = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        // A lock arriving on the timeout cycle still counts as a lock.
        if (lock_s) begin
          state_nxt = STABLE;
        end else if (cnt_q == LOCK_TO_LAST) begin
          retry_nxt = retry_inc;
          state_nxt = (retry_inc == RETRY_LIMIT) ? FAILED : PLL_RESET;
        end
      end
      STABLE: begin
        // Any dropout restarts the lock wait without charging a retry.
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_nxt = RUN;
          retry_nxt = '0;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = PLL_RESET;
        end
      end
      FAILED: begin
        state_nxt = FAILED;
      end
      default: begin
        state_nxt = PLL_RESET;
      end
    endcase

    if (seq.restart) begin
      state_nxt = PLL_RESET;
      retry_nxt = '0;
    end

    // Counter measures time in the current state only; idle in RUN/FAILED.
    if (seq.restart || (state_nxt != state_q) || (state_q == RUN) || (state_q == FAILED)) begin
      cnt_nxt = '0;
    end
  end

  // State, counter, retry count and registered output levels.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      state_q <= PLL_RESET;
      cnt_q   <= '0;
      retry_q <= '0;
      outs_q  <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      retry_q <= retry_nxt;
      outs_q  <= state_outputs(state_nxt);
    end
  end

  assign seq.pll_resetb  = outs_q.pll_resetb;
  assign seq.sys_reset_n = outs_q.sys_reset_n;
  assign seq.ready       = outs_q.ready;
  assign seq.fail        = outs_q.fail;
  assign seq.retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed vector table, corner sequences, randomized run vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_reset_sequencer;

  localparam int P_RST = 4;
  localparam int P_TO  = 20;
  localparam int P_STB = 8;
  localparam int P_MAX = 3;

  logic clock_in;
  logic resetb;
  int   tests;
  int   fails;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES (P_RST),
    .LOCK_TIMEOUT   (P_TO),
    .STABLE_CYCLES  (P_STB),
    .MAX_RETRIES    (P_MAX),
    .SYNC_STAGES    (2)
  ) dut (
    .clock_in (clock_in),
    .resetb   (resetb),
    .seq      (bus)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Reference model: phase plus the edge index at which it began.
  typedef enum int {M_RST, M_WAIT, M_STABLE, M_RUN, M_FAIL} mphase_t;
  mphase_t ph;
  int      t_now;
  int      t_start;
  int      retries;
  bit      lock_hist[$];

  typedef struct {
    int       n;
    bit       lk;
    bit       rs;
    bit [7:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %b required %b", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] dut_outs();
    return {bus.pll_resetb, bus.sys_reset_n, bus.ready, bus.fail, bus.retry_count};
  endfunction

  function automatic logic [7:0] model_outs();
    logic on;
    on = (ph == M_WAIT) || (ph == M_STABLE) || (ph == M_RUN);
    return {on, ph == M_RUN, ph == M_RUN, ph == M_FAIL, 4'(retries)};
  endfunction

  task automatic model_reset();
    ph      = M_RST;
    t_now   = 0;
    t_start = 0;
    retries = 0;
    lock_hist.delete();
  endtask

  task automatic enter(input mphase_t p);
    ph      = p;
    t_start = t_now;
  endtask

  // Lock as seen by the sequencer is the input sampled two edges earlier.
  task automatic model_edge();
    bit ls;
    int el;
    t_now++;
    ls = (lock_hist.size() >= 2) ? lock_hist[lock_hist.size()-2] : 1'b0;
    lock_hist.push_back(bus.pll_locked);
    if (lock_hist.size() > 4) void'(lock_hist.pop_front());
    el = t_now - t_start;
    if (bus.restart) begin
      retries = 0;
      enter(M_RST);
    end else begin
      case (ph)
        M_RST:    if (el == P_RST) enter(M_WAIT);
        M_WAIT: begin
          if (ls) enter(M_STABLE);
          else if (el == P_TO) begin
            retries = (retries < 15) ? retries + 1 : 15;
            enter((retries == P_MAX) ? M_FAIL : M_RST);
          end
        end
        M_STABLE: begin
          if (!ls) enter(M_WAIT);
          else if (el == P_STB) begin
            retries = 0;
            enter(M_RUN);
          end
        end
        M_RUN:    if (!ls) enter(M_RST);
        default:  ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clock_in);
    if (resetb) model_edge();
    @(negedge clock_in);
    check("model", dut_outs(), model_outs());
  endtask

  // Called just after a falling edge: reset lands mid-cycle, outputs must clear at once.
  task automatic async_reset(input string name);
    #2 resetb = 1'b0;
    #1 check(name, dut_outs(), 8'h00);
    model_reset();
    @(negedge clock_in);
    resetb = 1'b1;
  endtask

  task automatic add(input int n, input bit lk, input bit rs, input bit prb, input bit srn,
                     input bit rdy, input bit fl, input int rc);
    vec_t v;
    v.n   = n;
    v.lk  = lk;
    v.rs  = rs;
    v.exp = {prb, srn, rdy, fl, 4'(rc)};
    vecs.push_back(v);
  endtask

  initial begin
    int waited;
    int c;
    int run;
    bit lvl;
    tests          = 0;
    fails          = 0;
    resetb         = 1'b0;
    bus.pll_locked = 1'b0;
    bus.restart    = 1'b0;
    model_reset();

    // Edge numbers in comments count rising edges since reset release.
    add(3,  0, 0, 0, 0, 0, 0, 0);   // e3  still holding PLL in reset
    add(1,  0, 0, 1, 0, 0, 0, 0);   // e4  PLL released, waiting for lock
    add(2,  0, 0, 1, 0, 0, 0, 0);   // e6
    add(10, 1, 0, 1, 0, 0, 0, 0);   // e16 lock seen at e9, stable phase
    add(1,  1, 0, 1, 1, 1, 0, 0);   // e17 system released
    add(2,  0, 0, 1, 1, 1, 0, 0);   // e19 drop not yet through sync
    add(1,  0, 0, 0, 0, 0, 0, 0);   // e20 lock loss -> PLL reset
    add(3,  0, 0, 0, 0, 0, 0, 0);   // e23
    add(1,  0, 0, 1, 0, 0, 0, 0);   // e24 PLL reset pulse was 4 cycles
    add(5,  1, 0, 1, 0, 0, 0, 0);   // e29 glitch: 5 high
    add(1,  0, 0, 1, 0, 0, 0, 0);   // e30 1 low
    add(10, 1, 0, 1, 0, 0, 0, 0);   // e40 no early release
    add(1,  1, 0, 1, 1, 1, 0, 0);   // e41 8 stable cycles after re-rise
    add(3,  0, 0, 0, 0, 0, 0, 0);   // e44 lock lost again
    add(4,  0, 0, 1, 0, 0, 0, 0);   // e48 waiting
    add(19, 0, 0, 1, 0, 0, 0, 0);   // e67 last cycle before timeout
    add(1,  0, 0, 0, 0, 0, 0, 1);   // e68 first timeout
    add(3,  0, 0, 0, 0, 0, 0, 1);   // e71
    add(1,  0, 0, 1, 0, 0, 0, 1);   // e72
    add(20, 0, 0, 0, 0, 0, 0, 2);   // e92 second timeout
    add(23, 0, 0, 1, 0, 0, 0, 2);   // e115
    add(1,  0, 0, 0, 0, 0, 1, 3);   // e116 third timeout -> failed
    add(50, 0, 0, 0, 0, 0, 1, 3);   // e166 stays failed
    add(20, 1, 0, 0, 0, 0, 1, 3);   // e186 lock alone does not recover
    add(1,  1, 1, 0, 0, 0, 0, 0);   // e187 restart clears fail and retries
    add(4,  1, 0, 1, 0, 0, 0, 0);   // e191
    add(8,  1, 0, 1, 0, 0, 0, 0);   // e199
    add(1,  1, 0, 1, 1, 1, 0, 0);   // e200 recovered to run
    add(1,  1, 1, 0, 0, 0, 0, 0);   // e201 restart from run
    add(21, 0, 0, 1, 0, 0, 0, 0);   // e222 waiting since e205
    add(2,  1, 0, 1, 0, 0, 0, 0);   // e224
    add(1,  1, 0, 1, 0, 0, 0, 0);   // e225 lock and timeout together: lock wins
    add(5,  1, 0, 1, 0, 0, 0, 0);   // e230
    add(1,  0, 0, 1, 0, 0, 0, 0);   // e231
    add(2,  1, 0, 1, 0, 0, 0, 0);   // e233 drop on completion cycle wins
    add(8,  1, 0, 1, 0, 0, 0, 0);   // e241
    add(1,  1, 0, 1, 1, 1, 0, 0);   // e242 run

    repeat (3) @(negedge clock_in);
    check("reset_state", dut_outs(), 8'h00);
    resetb = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.pll_locked = vecs[i].lk;
      bus.restart    = vecs[i].rs;
      for (int k = 0; k < vecs[i].n; k++) step();
      check($sformatf("vec%0d", i), dut_outs(), vecs[i].exp);
    end
    bus.restart = 1'b0;

    // Async reset while in the stable phase.
    bus.pll_locked = 1'b0;
    repeat (3) step();
    bus.pll_locked = 1'b1;
    waited = 0;
    while (ph != M_STABLE && waited < 100) begin
      step();
      waited++;
    end
    check("reach_stable", {7'd0, ph == M_STABLE}, 8'h01);
    repeat (3) step();
    check("mid_stable", dut_outs(), 8'b1000_0000);
    async_reset("async_rst_stable");
    repeat (P_RST + 2 + P_STB + 2) step();
    check("relock_after_rst", dut_outs(), 8'b1110_0000);

    // Randomized lock runs with occasional restart pulses and async resets.
    c = 0;
    while (c < 2500) begin
      run = $urandom_range(1, 30);
      lvl = ($urandom_range(0, 3) != 0);
      bus.pll_locked = lvl;
      for (int k = 0; k < run; k++) begin
        bus.restart = ($urandom_range(0, 79) == 0);
        step();
        c++;
        if ($urandom_range(0, 599) == 0) async_reset("async_rst_rand");
      end
    end
    bus.restart = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
